mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 73 +++++++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared encodings for the two-requester memory arbiter: the three FSM
// states and the owner identifiers used by the arbiter and by rr_pick.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_IO  = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Chooses which of the two requesters (CPU or I/O) gets the next memory
// access.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : ties go to the requester that was not served last; a
//               last-served pointer is kept and updated on every grant.
//   undefined : ties always go to the CPU and no pointer exists.
//
// Ports
//   clk         in   clock, rising-edge active
//   reset       in   synchronous active-high reset (pointer -> IO)
//   cpu_req     in   CPU request
//   io_req      in   I/O request
//   grant_en    in   high in the cycle the arbiter accepts this grant
//   grant_valid out  at least one request is present
//   grant_owner out  selected owner (OWN_CPU / OWN_IO)
// ---------------------------------------------------------------------------
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic io_req,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_owner
);

    assign grant_valid = cpu_req | io_req;

`ifdef MEM_ARB_RR_EN

    owner_t lastServed_q;

    // Last-served pointer; resets to IO so the CPU takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastServed_q <= OWN_IO;
        end else if (grant_en) begin
            lastServed_q <= owner_t'(grant_owner);
        end
    end

    // A lone request always wins; a tie goes to whoever was not served last.
    always_comb begin
        grant_owner = OWN_CPU;
        if (cpu_req && io_req) begin
            grant_owner = (lastServed_q == OWN_CPU) ? OWN_IO : OWN_CPU;
        end else if (io_req) begin
            grant_owner = OWN_IO;
        end
    end

`else

    // Fixed priority: the CPU wins whenever it is requesting.
    always_comb begin
        grant_owner = OWN_CPU;
        if (!cpu_req && io_req) begin
            grant_owner = OWN_IO;
        end
    end

    // Clock, reset and grant_en only feed the pointer, which this build lacks.
    logic unused_ptrInputs;
    assign unused_ptrInputs = clk & reset & grant_en;

`endif

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous RAM (one-cycle read latency) between a
// CPU and an I/O (display/DMA) requester. Each access runs IDLE -> ACCESS ->
// DONE: requests are sampled only in IDLE, the memory outputs are held
// through ACCESS, and the owner's ack (with read data) is registered as the
// FSM returns to IDLE, so ack is high two cycles after the accepting edge.
//
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie breaking, in rr_pick)
//
// Ports
//   clk50MHz              in   clock, rising-edge active
//   reset                 in   synchronous active-high reset
//   cpu_req/cpu_we        in   CPU request / write enable
//   cpu_addr/cpu_wdata    in   CPU address / write data   [WIDTH]
//   cpu_ack               out  CPU completion pulse
//   cpu_rdata             out  CPU read data               [WIDTH]
//   io_*                  -    same set for the I/O requester
//   mem_we                out  RAM write enable
//   mem_addr/mem_wdata    out  RAM address / write data   [WIDTH]
//   mem_rdata             in   RAM read data              [WIDTH]
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk50MHz,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_ack,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             io_req,
    input  logic             io_we,
    input  logic [WIDTH-1:0] io_addr,
    input  logic [WIDTH-1:0] io_wdata,
    output logic             io_ack,
    output logic [WIDTH-1:0] io_rdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    state_t           state_q,    state_d;
    owner_t           owner_q,    owner_d;
    logic             accWe_q,    accWe_d;
    logic             memWe_q,    memWe_d;
    logic [WIDTH-1:0] memAddr_q,  memAddr_d;
    logic [WIDTH-1:0] memWdata_q, memWdata_d;
    logic             cpuAck_q,   cpuAck_d;
    logic             ioAck_q,    ioAck_d;
    logic [WIDTH-1:0] cpuRdata_q, cpuRdata_d;
    logic [WIDTH-1:0] ioRdata_q,  ioRdata_d;

    logic grantValid;
    logic grantOwner;
    logic grantEn;

    // The selector only advances its pointer when a grant is actually taken.
    assign grantEn = (state_q == S_IDLE) && grantValid;

    rr_pick u_pick (
        .clk         (clk50MHz),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .io_req      (io_req),
        .grant_en    (grantEn),
        .grant_valid (grantValid),
        .grant_owner (grantOwner)
    );

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk50MHz) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_CPU;
            accWe_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            cpuAck_q   <= 1'b0;
            ioAck_q    <= 1'b0;
            cpuRdata_q <= '0;
            ioRdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            accWe_q    <= accWe_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            cpuAck_q   <= cpuAck_d;
            ioAck_q    <= ioAck_d;
            cpuRdata_q <= cpuRdata_d;
            ioRdata_q  <= ioRdata_d;
        end
    end

    // Next-state logic. accWe_q remembers the direction of the access because
    // mem_we has already dropped by the time DONE decides whether to load
    // read data.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        accWe_d    = accWe_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        cpuAck_d   = 1'b0;
        ioAck_d    = 1'b0;
        cpuRdata_d = cpuRdata_q;
        ioRdata_d  = ioRdata_q;

        case (state_q)
            S_IDLE: begin
                memWe_d = 1'b0;
                if (grantValid) begin
                    state_d = S_ACCESS;
                    owner_d = owner_t'(grantOwner);
                    if (grantOwner == OWN_CPU) begin
                        accWe_d    = cpu_we;
                        memWe_d    = cpu_we;
                        memAddr_d  = cpu_addr;
                        memWdata_d = cpu_wdata;
                    end else begin
                        accWe_d    = io_we;
                        memWe_d    = io_we;
                        memAddr_d  = io_addr;
                        memWdata_d = io_wdata;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                memWe_d = 1'b0;
            end
            S_DONE: begin
                // RAM data for the address held in ACCESS is valid now.
                state_d = S_IDLE;
                if (owner_q == OWN_CPU) begin
                    cpuAck_d = 1'b1;
                    if (!accWe_q) begin
                        cpuRdata_d = mem_rdata;
                    end
                end else begin
                    ioAck_d = 1'b1;
                    if (!accWe_q) begin
                        ioRdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                memWe_d = 1'b0;
            end
        endcase
    end

    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign cpu_ack   = cpuAck_q;
    assign io_ack    = ioAck_q;
    assign cpu_rdata = cpuRdata_q;
    assign io_rdata  = ioRdata_q;

endmodule
